// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes decoded by the execute stage and
// produced by alu_control, plus a legality helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // True when the control code names one of the six defined operations.
    function automatic logic alu_is_legal(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result, signed add/sub overflow and illegal-code flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic                    sum_ovf;
    logic                    diff_ovf;
    logic                    less;

    assign a_s    = op_a;
    assign b_s    = op_b;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    // Same-sign operands producing an opposite-sign sum overflow; for a
    // subtraction the operands must differ in sign for overflow to occur.
    assign sum_ovf  = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1]  != a_s[WIDTH-1]);
    assign diff_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);

    // Sign of a-b is wrong exactly when a-b overflowed, so correct it.
    assign less = diff_s[WIDTH-1] ^ diff_ovf;

    // Decode the control code into the selected result and flags.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (alu_ctrl)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: begin
                result   = sum_s;
                overflow = sum_ovf;
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = diff_ovf;
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, less};
            ALU_NOR: result = ~(op_a | op_b);
            default: illegal = ~alu_is_legal(alu_ctrl);
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered output with a one-entry skid buffer so that
// in_ready comes straight from a flop while sustaining one op per cycle.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] result_p0;
    logic             zero_p0;
    logic             overflow_p0;
    logic             illegal_p0;
    logic             vld_p0;

    logic [WIDTH-1:0] skid_result_p1;
    logic             skid_zero_p1;
    logic             skid_overflow_p1;
    logic             skid_illegal_p1;
    logic             skid_vld_p1;
    logic             skid_vld_next;

    logic             drain;
    logic             load_out;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result_p0),
        .overflow (overflow_p0),
        .illegal  (illegal_p0)
    );

    assign zero_p0  = (result_p0 == '0);
    assign vld_p0   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    // Output register can take new content when it is empty or leaving now.
    assign load_out = !out_valid || drain;

    // Skid occupancy after this edge: it empties whenever the output register
    // loads (its content moves forward), and fills when an accept finds the
    // output register stalled.
    always_comb begin
        skid_vld_next = skid_vld_p1;
        if (load_out) begin
            skid_vld_next = 1'b0;
        end else if (vld_p0) begin
            skid_vld_next = 1'b1;
        end
    end

    // Stage p0 -> p1: output register, fed from the skid first, else from the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_out) begin
            out_valid <= skid_vld_p1 || vld_p0;
            if (skid_vld_p1) begin
                result   <= skid_result_p1;
                zero     <= skid_zero_p1;
                overflow <= skid_overflow_p1;
                illegal  <= skid_illegal_p1;
            end else if (vld_p0) begin
                result   <= result_p0;
                zero     <= zero_p0;
                overflow <= overflow_p0;
                illegal  <= illegal_p0;
            end
        end
    end

    // Skid register captures an accepted op while the output register is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_p1      <= 1'b0;
            skid_result_p1   <= '0;
            skid_zero_p1     <= 1'b0;
            skid_overflow_p1 <= 1'b0;
            skid_illegal_p1  <= 1'b0;
        end else begin
            skid_vld_p1 <= skid_vld_next;
            if (!load_out && vld_p0) begin
                skid_result_p1   <= result_p0;
                skid_zero_p1     <= zero_p0;
                skid_overflow_p1 <= overflow_p0;
                skid_illegal_p1  <= illegal_p0;
            end
        end
    end

    // in_ready is a dedicated flop mirroring "skid will be empty".
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= !skid_vld_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed corner cases plus randomized traffic,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_alu_exec_stage;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       alu_ctrl = 4'd0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    bit   rand_ready = 0;
    bit   rst_seen   = 0;
    bit   held       = 0;
    logic [34:0] held_val;

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.res = 32'd0;
        e.ovf = 1'b0;
        e.ill = 1'b0;
        case (c)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  begin r = sa + sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd6:  begin r = sa - sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: e.res = ~(a | b);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor / scoreboard: handshakes observed mid-cycle, acted on at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held = 0;
            if (rst_seen) begin
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_in_ready", 64'(in_ready), 64'd1);
            end
            rst_seen = 1;
        end else begin
            rst_seen = 0;
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({result, zero, overflow, illegal}), 64'(held_val));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(result), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_result", 64'(result), 64'(e.res));
                    check("sb_flags", 64'({zero, overflow, illegal}), 64'({e.zero, e.ovf, e.ill}));
                end
            end
            held     = out_valid && !out_ready;
            held_val = {result, zero, overflow, illegal};
            if (in_valid && in_ready) q.push_back(model(alu_ctrl, op_a, op_b));
        end
    end

    // Random backpressure source, active only while enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = $urandom_range(0, 1);
    end

    // Offer an op and wait (bounded) until it is accepted; returns just after the accept edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic logic [3:0] rand_ctrl();
        logic [3:0] codes [6];
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        if ($urandom_range(0, 5) == 0) return 4'($urandom_range(0, 15));
        return codes[$urandom_range(0, 5)];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_result", 64'({result, zero, overflow, illegal}), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // ADD overflow, one-cycle latency
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        idle();
        @(negedge clk);
        check("add_ovf_valid", 64'(out_valid), 64'd1);
        check("add_ovf_result", 64'({result, zero, overflow}), 64'({32'h8000_0000, 1'b0, 1'b1}));
        @(posedge clk);
        #1;

        // SUB to zero, SLT across sign, illegal code
        issue(4'b0110, 32'd5, 32'd5);
        issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
        issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();
        @(negedge clk);
        check("illegal_out", 64'({result, zero, overflow, illegal}), 64'({32'd0, 1'b1, 1'b0, 1'b1}));
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third blocked, then all drain in order
        out_ready = 1'b0;
        issue(4'b0010, 32'd10, 32'd20);
        issue(4'b0001, 32'h0F0F_0000, 32'h0000_F0F0);
        alu_ctrl = 4'b1100;
        op_a     = 32'h1234_5678;
        op_b     = 32'h0;
        @(negedge clk);
        check("skid_full_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'b1100, 32'h1234_5678, 32'h0);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset with both entries full; a handshake during reset is dropped
        out_ready = 1'b0;
        issue(4'b0000, 32'hFFFF_0000, 32'h00FF_FF00);
        issue(4'b0010, 32'd1, 32'd2);
        idle();
        @(negedge clk);
        check("both_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        alu_ctrl = 4'b0010;
        op_a     = 32'd3;
        op_b     = 32'd4;
        @(negedge clk);
        check("rst_full_outputs", 64'({out_valid, result, zero, overflow, illegal}), 64'd0);
        check("rst_full_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_dropped_op", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Throughput: back-to-back ops with out_ready held high
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            alu_ctrl = rand_ctrl();
            op_a     = $urandom;
            op_b     = $urandom;
            @(negedge clk);
            check("tput_in_ready", 64'(in_ready), 64'd1);
            if (i > 0) check("tput_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        idle();

        // Random traffic with random backpressure
        rand_ready = 1;
        for (int i = 0; i < 100; i++) begin
            int gap;
            logic [31:0] a;
            logic [31:0] b;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue(rand_ctrl(), a, b);
            idle();
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
